// File: rtl/fetch_unit_if.sv
// IF-stage bus bundle: decode handshake, EX redirect, instruction ROM port and
// the buffer-head outputs that feed the IF/ID register.
interface fetch_unit_if #(
    parameter int unsigned IMEM_AW   = 10,
    parameter int unsigned BUF_DEPTH = 2
);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    // decode / EX side
    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;

    // instruction ROM side
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    // buffer head towards IF/ID
    logic               instn_valid;
    logic [31:0]        instn;
    logic [31:0]        instn_pc;
    logic [31:0]        instn_pc_plus4;
    logic [CW-1:0]      buf_count;

    // Fetch unit side
    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        output imem_en,
        output imem_addr,
        output instn_valid,
        output instn,
        output instn_pc,
        output instn_pc_plus4,
        output buf_count
    );

    // Pipeline / memory environment side
    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        input  imem_en,
        input  imem_addr,
        input  instn_valid,
        input  instn,
        input  instn_pc,
        input  instn_pc_plus4,
        input  buf_count
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS IF stage: owns the PC, issues one-word reads to a 1-cycle synchronous ROM
// and queues returned words in a small circular buffer so decode stalls never
// lose a fetch. An EX redirect flushes the buffer and any in-flight read.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_AW   = 10,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    // pointer, occupancy and headroom widths
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    // architectural state
    logic [31:0]   pc_q, pc_d;
    logic          pending_q, pending_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // buffer storage; entries are only observed while counted as occupied
    logic [31:0]   buf_instn_q [BUF_DEPTH];
    logic [31:0]   buf_pc_q    [BUF_DEPTH];

    // per-cycle control
    logic          flush_c;
    logic          head_valid_c;
    logic          pop_c;
    logic          push_c;
    logic          issue_c;
    logic [OW-1:0] occ_c;

    // Handshake decisions: redirect overrides pop, push and issue
    always_comb begin
        flush_c      = bus.redirect_valid;
        head_valid_c = (count_q != '0);
        pop_c        = head_valid_c & ~bus.stall & ~flush_c;
        push_c       = pending_q & ~flush_c;
        // entries that will be held after this edge if nothing new is issued
        occ_c        = OW'(count_q) + OW'(pending_q) - OW'(pop_c);
        issue_c      = ~reset & ~flush_c & (occ_c < OW'(BUF_DEPTH));
    end

    // Next-state for PC, outstanding read and buffer bookkeeping
    always_comb begin
        pc_d      = pc_q;
        pending_d = pending_q;
        req_pc_d  = req_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        if (flush_c) begin
            // word-align the target; the read returning next cycle is dropped
            pc_d      = bus.redirect_pc & 32'hFFFF_FFFC;
            pending_d = 1'b0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            pending_d = issue_c;
            if (issue_c) begin
                pc_d     = pc_q + 32'd4;
                req_pc_d = pc_q;
            end
            // pointers wrap naturally because BUF_DEPTH is a power of two
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            req_pc_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
            req_pc_q  <= req_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Capture the returning ROM word with the PC it was fetched from
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            buf_instn_q[wr_ptr_q] <= bus.imem_rdata;
            buf_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // ROM port: enable follows the issue decision within the same cycle
    assign bus.imem_en   = issue_c;
    assign bus.imem_addr = pc_q[IMEM_AW+1:2];

    // Buffer head; zeroed while empty so an idle stage presents a clean bubble
    assign bus.instn_valid    = head_valid_c;
    assign bus.instn          = head_valid_c ? buf_instn_q[rd_ptr_q] : '0;
    assign bus.instn_pc       = head_valid_c ? buf_pc_q[rd_ptr_q] : '0;
    assign bus.instn_pc_plus4 = head_valid_c ? (buf_pc_q[rd_ptr_q] + 32'd4) : '0;
    assign bus.buf_count      = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/redirect/reset traffic, all compared every cycle against a queue-based
// transaction model of the fetch stream.
module tb_fetch_unit;
    localparam int unsigned IMEM_AW   = 10;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned ROM_WORDS = 1 << IMEM_AW;

    logic clk;
    logic reset;

    fetch_unit_if #(.IMEM_AW(IMEM_AW), .BUF_DEPTH(BUF_DEPTH)) bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] rom [ROM_WORDS];
    int n_asserts = 0;
    int n_fail    = 0;

    // reference model: next PC to fetch, buffered PCs, reads in flight
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic [31:0] m_fl[$];
    logic        m_pop;
    logic        m_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous ROM; garbage on idle cycles exposes any stray capture
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];
        else             bus.imem_rdata <= $urandom();
    end

    function automatic logic [31:0] rom_at(input logic [31:0] pc);
        return rom[pc[IMEM_AW+1:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // compare this cycle's DUT outputs with what the model predicts
    task automatic check_outputs(input logic st, input logic rv, input logic rs);
        logic val;
        int   occ;
        val   = (m_q.size() != 0);
        m_pop = val & ~st & ~rv;
        occ   = m_q.size() + m_fl.size() - (m_pop ? 1 : 0);
        m_en  = ~rs & ~rv & (occ < int'(BUF_DEPTH));
        chk("imem_en",     32'(bus.imem_en),     32'(m_en));
        chk("imem_addr",   32'(bus.imem_addr),   32'(m_pc[IMEM_AW+1:2]));
        chk("instn_valid", 32'(bus.instn_valid), 32'(val));
        chk("buf_count",   32'(bus.buf_count),   32'(m_q.size()));
        if (val) begin
            chk("instn",          bus.instn,          rom_at(m_q[0]));
            chk("instn_pc",       bus.instn_pc,       m_q[0]);
            chk("instn_pc_plus4", bus.instn_pc_plus4, m_q[0] + 32'd4);
        end
    endtask

    // advance the model across the clock edge
    task automatic model_step(input logic rv, input logic [31:0] rp, input logic rs);
        if (rs) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_fl.delete();
        end else if (rv) begin
            m_pc = {rp[31:2], 2'b00};
            m_q.delete();
            m_fl.delete();
        end else begin
            if (m_pop) void'(m_q.pop_front());
            if (m_fl.size() != 0) m_q.push_back(m_fl.pop_front());
            if (m_en) begin
                m_fl.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // one clock cycle: drive inputs, check outputs, step the model
    task automatic cycle(input logic st, input logic rv, input logic [31:0] rp, input logic rs);
        @(negedge clk);
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        reset              = rs;
        #1;
        check_outputs(st, rv, rs);
        model_step(rv, rp, rs);
    endtask

    initial begin
        for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = $urandom();
        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        m_pc               = RESET_PC;
        m_q.delete();
        m_fl.delete();
        repeat (2) @(posedge clk);

        // reset values
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_imem_en",   32'(bus.imem_en),     32'h0);
        chk("rst_valid",     32'(bus.instn_valid), 32'h0);
        chk("rst_instn",     bus.instn,            32'h0);
        chk("rst_pc",        bus.instn_pc,         32'h0);
        chk("rst_pc_plus4",  bus.instn_pc_plus4,   32'h0);
        chk("rst_buf_count", 32'(bus.buf_count),   32'h0);

        // 1: stream from RESET_PC, first valid on cycle 2, one word per cycle
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_en_c0", 32'(bus.imem_en), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_valid_c1", 32'(bus.instn_valid), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_valid_c2", 32'(bus.instn_valid), 32'h1);
        chk("t1_pc_c2",    bus.instn_pc,         32'h0);
        chk("t1_instn_c2", bus.instn,            rom[0]);
        for (int k = 3; k < 10; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            chk("t1_pc_seq", bus.instn_pc, 32'(4 * (k - 2)));
        end

        // 2: four-cycle stall holds the head, buffer fills, fetch stops
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            chk("t2_hold_pc", bus.instn_pc, 32'h20);
        end
        chk("t2_buf_full", 32'(bus.buf_count), 32'h2);
        chk("t2_en_off",   32'(bus.imem_en),   32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            chk("t2_resume_pc", bus.instn_pc, 32'(32'h20 + 32'(4 * k)));
        end

        // 3: redirect to 0x40 while full
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_full", 32'(bus.buf_count), 32'h2);
        cycle(1'b0, 1'b1, 32'h40, 1'b0);
        chk("t3_en_redirect", 32'(bus.imem_en), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_flushed", 32'(bus.instn_valid), 32'h0);
        chk("t3_refetch", 32'(bus.imem_addr),   32'h10);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_bubble", 32'(bus.instn_valid), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_target", bus.instn_pc, 32'h40);

        // 4: unaligned target together with stall; flush still wins
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h43, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_flushed", 32'(bus.instn_valid), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_aligned", bus.instn_pc, 32'h40);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // 5: PC and ROM address wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_addr_top", 32'(bus.imem_addr), 32'h3FF);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_addr_wrap", 32'(bus.imem_addr), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_pc_top",    bus.instn_pc,       32'hFFFF_FFFC);
        chk("t5_plus4_wrap", bus.instn_pc_plus4, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_pc_wrap", bus.instn_pc, 32'h0);

        // 6: reset with a full buffer
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_full", 32'(bus.buf_count), 32'h2);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_en",     32'(bus.imem_en),     32'h0);
        chk("t6_valid",  32'(bus.instn_valid), 32'h0);
        chk("t6_count",  32'(bus.buf_count),   32'h0);
        chk("t6_instn",  bus.instn,            32'h0);
        chk("t6_pc",     bus.instn_pc,         32'h0);
        chk("t6_plus4",  bus.instn_pc_plus4,   32'h0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_restart", bus.instn_pc, RESET_PC);

        // random stall / redirect / reset traffic
        for (int i = 0; i < 600; i++) begin
            logic        st;
            logic        rv;
            logic        rs;
            logic [31:0] rp;
            st = ($urandom_range(0, 99) < 30);
            rv = ($urandom_range(0, 99) < 6);
            rs = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           rp = $urandom();
            cycle(st, rv, rp, rs);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
